player_death_ctrl: RTL and testbench

//  Upstream stage of the player-life display. Detects player/monster pixel overlap during a frame and

---
 rtl/player_death_ctrl.sv | 126 ++++++++++++
 tb/tb_player_death_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/player_death_ctrl.sv
// Player hit detection and death/respawn/invulnerability sequencing, paced by startOfFrame.
// Emits one player_died pulse per death and latches game_over when lives run out.
module player_death_ctrl #(
  parameter int unsigned DEATH_FRAMES  = 64,
  parameter int unsigned INVULN_FRAMES = 96,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic player_dr,
  input  logic monster_dr,
  input  logic bonus_mode,
  input  logic no_lives,
  output logic player_died,
  output logic player_frozen,
  output logic respawn_req,
  output logic invulnerable,
  output logic game_over
);

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    DYING     = 2'd1,
    INVULN    = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEATH_LOAD  = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0] INVULN_LOAD = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hit_flag, hit_nxt;
  logic             overlap;
  logic             died_nxt, resp_nxt;
  logic             frozen_nxt, invuln_nxt, over_nxt;

  assign overlap = player_dr & monster_dr & ~bonus_mode;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= ALIVE;
      cnt           <= '0;
      hit_flag      <= 1'b0;
      player_died   <= 1'b0;
      player_frozen <= 1'b0;
      respawn_req   <= 1'b0;
      invulnerable  <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      hit_flag      <= hit_nxt;
      player_died   <= died_nxt;
      player_frozen <= frozen_nxt;
      respawn_req   <= resp_nxt;
      invulnerable  <= invuln_nxt;
      game_over     <= over_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    died_nxt  = 1'b0;
    resp_nxt  = 1'b0;

    case (state)
      ALIVE: begin
        if (startOfFrame && hit_flag) begin
          state_nxt = DYING;
          cnt_nxt   = DEATH_LOAD;
          died_nxt  = 1'b1;
        end
      end
      DYING: begin
        if (startOfFrame) begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CNT_ONE;
          end else if (no_lives) begin
            state_nxt = GAME_OVER;
          end else begin
            state_nxt = INVULN;
            cnt_nxt   = INVULN_LOAD;
            resp_nxt  = 1'b1;
          end
        end
      end
      INVULN: begin
        if (startOfFrame) begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CNT_ONE;
          end else begin
            state_nxt = ALIVE;
          end
        end
      end
      GAME_OVER: begin
        state_nxt = GAME_OVER;
      end
      default: begin
        state_nxt = ALIVE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Flag accumulates over a frame; the overlap seen in the SOF cycle itself starts the new frame.
  always_comb begin
    hit_nxt = 1'b0;
    if (state == ALIVE) begin
      if (startOfFrame) hit_nxt = overlap;
      else              hit_nxt = hit_flag | overlap;
    end
  end

  // Level outputs are decoded from the next state so they are registered in step with it.
  always_comb begin
    frozen_nxt = (state_nxt == DYING) || (state_nxt == GAME_OVER);
    invuln_nxt = (state_nxt == INVULN);
    over_nxt   = (state_nxt == GAME_OVER);
  end

endmodule

// File: tb/tb_player_death_ctrl.sv
// Self-checking bench for player_death_ctrl: directed vector table, hand sequences for
// game-over and async reset, and randomized traffic against a frame-counting reference model.
module tb_player_death_ctrl;

  localparam int unsigned DF = 4;
  localparam int unsigned IF = 3;

  logic clk, resetN;
  logic startOfFrame, player_dr, monster_dr, bonus_mode, no_lives;
  logic player_died, player_frozen, respawn_req, invulnerable, game_over;

  int errors = 0;
  int checks = 0;

  player_death_ctrl #(.DEATH_FRAMES(DF), .INVULN_FRAMES(IF), .CNT_W(8)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .player_dr(player_dr), .monster_dr(monster_dr), .bonus_mode(bonus_mode),
    .no_lives(no_lives), .player_died(player_died), .player_frozen(player_frozen),
    .respawn_req(respawn_req), .invulnerable(invulnerable), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode plus number of SOFs seen since entering the mode.
  localparam int M_ALIVE = 0, M_DYING = 1, M_INV = 2, M_OVER = 3;
  int m_mode;
  int m_sofs;
  bit m_hit;
  bit e_died, e_resp;

  function automatic logic [4:0] outs();
    return {player_died, player_frozen, respawn_req, invulnerable, game_over};
  endfunction

  function automatic logic [4:0] model_exp();
    return {e_died, (m_mode == M_DYING) || (m_mode == M_OVER), e_resp,
            m_mode == M_INV, m_mode == M_OVER};
  endfunction

  task automatic model_reset();
    m_mode = M_ALIVE; m_sofs = 0; m_hit = 0; e_died = 0; e_resp = 0;
  endtask

  task automatic model_step(input bit sof, p, m, b, nl);
    int  old_mode;
    bit  ovl;
    old_mode = m_mode;
    ovl = p && m && !b;
    e_died = 0; e_resp = 0;
    if (sof) begin
      if (m_mode == M_ALIVE) begin
        if (m_hit) begin m_mode = M_DYING; m_sofs = 0; e_died = 1; end
      end else if (m_mode == M_DYING) begin
        m_sofs++;
        if (m_sofs == DF) begin
          if (nl) m_mode = M_OVER;
          else begin m_mode = M_INV; m_sofs = 0; e_resp = 1; end
        end
      end else if (m_mode == M_INV) begin
        m_sofs++;
        if (m_sofs == IF) m_mode = M_ALIVE;
      end
    end
    if (old_mode != M_ALIVE) m_hit = 0;
    else if (sof)            m_hit = ovl;
    else                     m_hit = m_hit || ovl;
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got died,frozen,resp,inv,over=%b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic sof, p, m, b, nl);
    startOfFrame = sof; player_dr = p; monster_dr = m; bonus_mode = b; no_lives = nl;
    @(posedge clk); #1;
    model_step(sof, p, m, b, nl);
  endtask

  task automatic do_reset();
    startOfFrame = 0; player_dr = 0; monster_dr = 0; bonus_mode = 0; no_lives = 0;
    resetN = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 5'b00000);
    resetN = 1;
    model_reset();
  endtask

  typedef struct packed {
    logic       sof, p, m, b, nl;
    logic [4:0] exp;
  } vec_t;

  function automatic vec_t vec(input logic sof, p, m, b, nl, input logic [4:0] exp);
    vec_t v;
    v.sof = sof; v.p = p; v.m = m; v.b = b; v.nl = nl; v.exp = exp;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    resetN = 1;
    model_reset();

    // Test 1: idle frames
    do_reset();
    for (int f = 0; f < 10; f++) begin
      step(1, 0, 0, 0, 0); check("idle", outs(), 5'b00000);
      step(0, 1, 0, 0, 0); check("idle", outs(), 5'b00000);
      step(0, 0, 1, 0, 0); check("idle", outs(), 5'b00000);
    end

    // Tests 2, 3, 5 and the start of 4 as one directed table; exp = died,frozen,resp,inv,over
    do_reset();
    tbl.push_back(vec(1,0,0,0,0, 5'b00000)); // SOF#1
    for (int i = 0; i < 5; i++) tbl.push_back(vec(0,1,1,0,0, 5'b00000));
    tbl.push_back(vec(1,0,0,0,0, 5'b11000)); // SOF#2: one death
    tbl.push_back(vec(0,0,0,0,0, 5'b01000));
    tbl.push_back(vec(1,0,0,0,0, 5'b01000)); // SOF#3
    tbl.push_back(vec(1,0,0,0,0, 5'b01000)); // SOF#4
    tbl.push_back(vec(1,0,0,0,0, 5'b01000)); // SOF#5
    tbl.push_back(vec(1,0,0,0,0, 5'b00110)); // SOF#6: respawn
    tbl.push_back(vec(0,1,1,0,0, 5'b00010)); // overlap ignored while invulnerable
    tbl.push_back(vec(1,0,0,0,0, 5'b00010));
    tbl.push_back(vec(1,0,0,0,0, 5'b00010));
    tbl.push_back(vec(1,1,1,0,0, 5'b00000)); // back to ALIVE; SOF-cycle overlap not seeded
    tbl.push_back(vec(1,0,0,0,0, 5'b00000));
    tbl.push_back(vec(1,1,1,1,0, 5'b00000)); // bonus overlap
    tbl.push_back(vec(0,1,1,1,0, 5'b00000));
    tbl.push_back(vec(1,0,0,0,0, 5'b00000));
    tbl.push_back(vec(1,1,1,0,0, 5'b00000)); // overlap in SOF cycle only
    tbl.push_back(vec(1,0,0,0,0, 5'b11000)); // registered one frame later
    tbl.push_back(vec(1,0,0,0,1, 5'b01000));
    tbl.push_back(vec(1,0,0,0,1, 5'b01000));
    tbl.push_back(vec(1,0,0,0,1, 5'b01000));
    tbl.push_back(vec(1,0,0,0,1, 5'b01001)); // no lives: game over, no respawn
    tbl.push_back(vec(1,1,1,0,0, 5'b01001));
    foreach (tbl[i]) begin
      step(tbl[i].sof, tbl[i].p, tbl[i].m, tbl[i].b, tbl[i].nl);
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Test 3 tail: overlap in the first frame after invulnerability ends -> death
    do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0); check("inv_tail_die", outs(), 5'b11000);
    for (int i = 0; i < DF - 1; i++) begin step(1, 0, 0, 0, 0); check("inv_tail_dying", outs(), 5'b01000); end
    step(1, 0, 0, 0, 0); check("inv_tail_resp", outs(), 5'b00110);
    step(0, 1, 1, 0, 0); check("inv_tail_ign", outs(), 5'b00010);
    step(1, 0, 0, 0, 0); check("inv_tail_inv", outs(), 5'b00010);
    step(1, 0, 0, 0, 0); check("inv_tail_inv", outs(), 5'b00010);
    step(1, 0, 0, 0, 0); check("inv_tail_alive", outs(), 5'b00000);
    step(0, 1, 1, 0, 0); check("inv_tail_ovl", outs(), 5'b00000);
    step(1, 0, 0, 0, 0); check("inv_tail_die2", outs(), 5'b11000);

    // Test 4: game over absorbs 20 frames of overlaps
    do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1);
    step(1, 0, 0, 0, 1); check("go_die", outs(), 5'b11000);
    for (int i = 0; i < DF - 1; i++) begin step(1, 0, 0, 0, 1); check("go_dying", outs(), 5'b01000); end
    step(1, 0, 0, 0, 1); check("go_enter", outs(), 5'b01001);
    for (int f = 0; f < 20; f++) begin
      step(1, 1, 1, 0, f[0]); check("go_hold", outs(), 5'b01001);
      step(0, 1, 1, 0, 0);    check("go_hold", outs(), 5'b01001);
    end

    // Test 6: async reset in DYING with cnt=2
    do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0); check("ar_die", outs(), 5'b11000);
    step(1, 0, 0, 0, 0); check("ar_cnt2", outs(), 5'b01000);
    #3 resetN = 0;
    #1 check("ar_async", outs(), 5'b00000);
    @(posedge clk); #1 check("ar_held", outs(), 5'b00000);
    resetN = 1;
    model_reset();
    for (int f = 0; f < 12; f++) begin
      step(1, 0, 0, 0, 0); check("ar_after", outs(), 5'b00000);
      step(0, 0, 0, 0, 0); check("ar_after", outs(), 5'b00000);
    end

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      begin
        logic sof, p, m, b, nl;
        sof = ($urandom_range(0, 3) == 0);
        p   = ($urandom_range(0, 3) == 0);
        m   = ($urandom_range(0, 2) == 0);
        b   = ($urandom_range(0, 4) == 0);
        nl  = ($urandom_range(0, 3) == 0);
        step(sof, p, m, b, nl);
        check("random", outs(), model_exp());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
